// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and adder slice width for the multiplier family
package mult_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam int         CLA_SLICE = 4;
endpackage

// File: rtl/cla_adder_w.sv
// cla_adder_w: WIDTH-bit adder built from ripple-chained 4-bit carry-lookahead slices
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_adder_w
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NS = WIDTH / CLA_SLICE;
    logic [NS:0] c;
    assign c[0] = cin;
    assign cout = c[NS];
    for (genvar i = 0; i < NS; i++) begin : g_slice
        cla4 u_slice (
            .a   (a[i*CLA_SLICE +: CLA_SLICE]),
            .b   (b[i*CLA_SLICE +: CLA_SLICE]),
            .cin (c[i]),
            .sum (sum[i*CLA_SLICE +: CLA_SLICE]),
            .cout(c[i+1])
        );
    end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential radix-2 shift-and-add unsigned multiplier with valid/ready handshakes
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);

    if (WIDTH < CLA_SLICE || WIDTH % CLA_SLICE != 0) begin : g_bad_width
        $error("shift_add_multiplier: WIDTH must be a multiple of 4 and >= 4");
    end

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand, acc_hi, mq, addend, s;
    logic               c, accept, last;
    logic [2*WIDTH-1:0] shifted;

    assign in_ready = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));
    assign addend   = mq[0] ? mcand : '0;
    // The adder carry-out becomes the top bit of the accumulator after the shift, so nothing is lost
    assign shifted  = {c, s, mq[WIDTH-1:1]};

    cla_adder_w #(.WIDTH(WIDTH)) u_add (
        .a   (acc_hi),
        .b   (addend),
        .cin (1'b0),
        .sum (s),
        .cout(c)
    );

    // FSM, datapath shift/accumulate and output handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            mq        <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                mcand  <= a;
                mq     <= b;
                acc_hi <= '0;
                cnt    <= '0;
                state  <= ST_RUN;
            end else if (state == ST_RUN) begin
                {acc_hi, mq} <= shifted;
                cnt          <= cnt + 1'b1;
                if (last) begin
                    product   <= shifted;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
            end else if ((state == ST_DONE && out_ready) || state == 2'd3) begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and random scoreboard bench for the shift-add multiplier
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b;
    logic [31:0] product;
    logic        iv8, ir8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int n_chk = 0;
    int n_pass = 0;
    int n_in = 0;
    int n_out = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .product(product8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard: pop and compare on output handshake, push on input handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("sb_underflow", 64'(q.size()), 64'd1);
                else check("sb_prod", product, q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(32'(a) * 32'(b));
                n_in++;
            end
        end
    end

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp);
        int n;
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = ~y;
        wait_out(n);
        check("latency", 64'(n), 64'd16);
        check("product", product, exp);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_in0, n_out0, guard;
        bit took;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'd3, 16'd5, 32'h0000000F);
        do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        do_op(16'h0000, 16'h1234, 32'h0);
        do_op(16'h1234, 16'h0000, 32'h0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        a = 16'd5; b = 16'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'd9; b = 16'd9;
        repeat (3) @(posedge clk);
        #1;
        check("run_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_out(n);
        check("bp_latency", 64'(n), 64'd13);
        check("bp_product", product, 32'd30);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_hold", product, 32'd30);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 16'd7; b = 16'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("restart_valid", 64'(out_valid), 64'd0);
        check("restart_in_ready", 64'(in_ready), 64'd0);
        wait_out(n);
        check("restart_latency", 64'(n), 64'd16);
        check("restart_product", product, 32'd63);
        @(posedge clk); #1;

        a = 16'hABCD; b = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_product", product, 32'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(16'd2, 16'd3, 32'd6);
        @(posedge clk); #1;

        a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_latency", 64'(n), 64'd8);
        check("w8_product", 64'(product8), 64'hFE01);

        n_in0 = n_in; n_out0 = n_out;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            took = 1'b0; guard = 0;
            while (!took && guard < 200) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                took = in_valid && in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!took) check("rand_accept_timeout", 64'(took), 64'd1);
            in_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                out_ready = ($urandom_range(0, 1) != 0);
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        check("rand_inputs", 64'(n_in - n_in0), 64'd2000);
        check("rand_in_out", 64'(n_out - n_out0), 64'(n_in - n_in0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
